// File: rtl/mux_pkg.sv
// Shared definitions for the 8-lane mux/demux pair.
// Lane count, output-register state and one-hot helpers.
package mux_pkg;

   localparam int NUM_LANES = 8;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   // One-hot select code to lane index
   function automatic logic [2:0] oh2idx(input logic [7:0] oh);
      logic [2:0] r;
      r = '0;
      for (int i = 0; i < NUM_LANES; i++) begin
         if (oh[i]) r = r | 3'(i);
      end
      return r;
   endfunction

   // Lane index to one-hot select code
   function automatic logic [7:0] idx2oh(input logic [2:0] idx);
      return 8'd1 << idx;
   endfunction

endpackage

// File: rtl/mux_8_1_rr_v_pick.sv
// Rotating-priority picker for eight lanes.
// Search starts at i_ptr and wraps; first eligible lane wins.
module rr_pick_8_v
   import mux_pkg::*;
(
   input  logic [7:0] i_elig,
   input  logic [2:0] i_ptr,
   output logic [7:0] o_gnt,
   output logic [2:0] o_idx,
   output logic       o_any
);

   logic [7:0] w_gnt;
   logic       w_found;
   logic [2:0] w_j;

   // Walk lanes ptr, ptr+1, ... mod 8 and grant the first eligible one
   always_comb begin
      w_gnt   = '0;
      w_found = 1'b0;
      w_j     = '0;
      for (int i = 0; i < NUM_LANES; i++) begin
         w_j = i_ptr + 3'(i);
         if (!w_found && i_elig[w_j]) begin
            w_gnt[w_j] = 1'b1;
            w_found    = 1'b1;
         end
      end
   end

   assign o_gnt = w_gnt;
   assign o_idx = oh2idx(w_gnt);
   assign o_any = w_found;

endmodule

// File: rtl/mux_8_1_rr_v.sv
// 8-to-1 round-robin collector onto one valid/ready stream.
// Publishes the grant as a one-hot select code and acks the lane.
module mux_8_1_rr_v
   import mux_pkg::*;
#(
   parameter int W = 8
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic [7:0]       i_req,
   input  logic [8*W-1:0]   i_data,
   input  logic             i_ready,
   output logic             o_valid,
   output logic [W-1:0]     o_data,
   output logic [7:0]       o_sel_code,
   output logic [7:0]       o_ack
);

   state_t         r_state;
   logic [2:0]     r_ptr;
   logic [W-1:0]   r_data;
   logic [7:0]     r_sel;
   logic [7:0]     r_ack;

   logic [W-1:0]   w_lane [NUM_LANES];
   logic [7:0]     w_elig;
   logic [7:0]     w_gnt;
   logic [2:0]     w_idx;
   logic           w_any;
   logic           w_load;

   for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
      assign w_lane[k] = i_data[k*W +: W];
   end

   // A lane acked this cycle is masked so a slow-dropping req is not recaptured
   assign w_elig = i_req & ~r_ack;
   assign w_load = (r_state == EMPTY) | i_ready;

   rr_pick_8_v u_pick (
      .i_elig (w_elig),
      .i_ptr  (r_ptr),
      .o_gnt  (w_gnt),
      .o_idx  (w_idx),
      .o_any  (w_any)
   );

   // Output register: load a winner, drain to EMPTY, or hold under backpressure
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= EMPTY;
         r_ptr   <= '0;
         r_data  <= '0;
         r_sel   <= '0;
         r_ack   <= '0;
      end else begin
         r_ack <= '0;
         if (w_load) begin
            if (w_any) begin
               r_state <= FULL;
               r_data  <= w_lane[w_idx];
               r_sel   <= w_gnt;
               r_ack   <= w_gnt;
               r_ptr   <= w_idx + 3'd1;
            end else begin
               r_state <= EMPTY;
               r_sel   <= '0;
            end
         end
      end
   end

   assign o_valid    = (r_state == FULL);
   assign o_data     = r_data;
   assign o_sel_code = r_sel;
   assign o_ack      = r_ack;

endmodule

// File: tb/tb_mux_8_1_rr_v.sv
// Self-checking bench for mux_8_1_rr_v.
// Directed table, hand sequences, and randomized model comparison.
module tb_mux_8_1_rr_v;

   localparam int W = 8;

   logic           clk;
   logic           rst_n;
   logic [7:0]     req;
   logic [8*W-1:0] dat;
   logic           rdy;
   logic           o_valid;
   logic [W-1:0]   o_data;
   logic [7:0]     o_sel;
   logic [7:0]     o_ack;

   int n_chk;
   int n_fail;

   mux_8_1_rr_v #(.W(W)) dut (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_req      (req),
      .i_data     (dat),
      .i_ready    (rdy),
      .o_valid    (o_valid),
      .o_data     (o_data),
      .o_sel_code (o_sel),
      .o_ack      (o_ack)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]  req;
      logic        rdy;
      logic [63:0] dat;
      logic        ev;
      logic [7:0]  ed;
      logic [7:0]  es;
      logic [7:0]  ea;
   } vec_t;

   vec_t tbl[14];

   // behavioural model state
   bit        m_valid;
   int        m_data;
   int        m_sel;
   int        m_ack;
   int        m_ptr;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h @%0t", nm, act, exp,
                  $time);
      end
   endtask

   task automatic chk_out(input string tag, input logic ev,
                          input logic [7:0] ed, input logic [7:0] es,
                          input logic [7:0] ea);
      chk({tag, ".valid"}, 64'(o_valid), 64'(ev));
      chk({tag, ".data"},  64'(o_data),  64'(ed));
      chk({tag, ".sel"},   64'(o_sel),   64'(es));
      chk({tag, ".ack"},   64'(o_ack),   64'(ea));
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic void m_reset();
      m_valid = 0;
      m_data  = 0;
      m_sel   = 0;
      m_ack   = 0;
      m_ptr   = 0;
   endfunction

   // One clock of the spec's rules, on the inputs present before the edge
   function automatic void m_next(input logic [7:0] rq,
                                  input logic [63:0] d,
                                  input logic ry);
      int elig;
      int win;
      elig = int'(rq) & ~m_ack;
      win  = -1;
      if (!m_valid || ry) begin
         for (int o = 0; o < 8; o++) begin
            int k;
            k = (m_ptr + o) % 8;
            if (win < 0 && elig[k]) win = k;
         end
         if (win >= 0) begin
            m_valid = 1;
            m_data  = int'((d >> (8 * win)) & 64'hFF);
            m_sel   = 1 << win;
            m_ack   = 1 << win;
            m_ptr   = (win + 1) % 8;
         end else begin
            m_valid = 0;
            m_sel   = 0;
            m_ack   = 0;
         end
      end else begin
         m_ack = 0;
      end
   endfunction

   localparam logic [63:0] BASE = 64'h1716_1514_1312_1110;
   localparam logic [63:0] BA5  = 64'h1716_1514_A512_1110;

   logic [7:0]  pend;
   logic [63:0] lane_d;
   int          acks;

   initial begin
      n_chk  = 0;
      n_fail = 0;
      req    = '0;
      dat    = '0;
      rdy    = 1'b0;
      rst_n  = 1'b1;

      for (int k = 0; k < 9; k++) begin
         tbl[k] = '{8'hFF, 1'b1, BASE, 1'b1, 8'(8'h10 + (k % 8)),
                    8'(1 << (k % 8)), 8'(1 << (k % 8))};
      end
      tbl[9]  = '{8'h08, 1'b1, BA5,  1'b1, 8'hA5, 8'h08, 8'h08};
      tbl[10] = '{8'h00, 1'b1, BA5,  1'b0, 8'hA5, 8'h00, 8'h00};
      tbl[11] = '{8'h80, 1'b1, BASE, 1'b1, 8'h17, 8'h80, 8'h80};
      tbl[12] = '{8'h81, 1'b1, BASE, 1'b1, 8'h10, 8'h01, 8'h01};
      tbl[13] = '{8'h80, 1'b1, BASE, 1'b1, 8'h17, 8'h80, 8'h80};

      // reset state
      #2 rst_n = 1'b0;
      #1 chk_out("reset", 1'b0, 8'h00, 8'h00, 8'h00);
      @(negedge clk);
      rst_n = 1'b1;

      // round robin, single request, fairness after wrap
      for (int i = 0; i < 14; i++) begin
         req = tbl[i].req;
         rdy = tbl[i].rdy;
         dat = tbl[i].dat;
         step();
         chk_out($sformatf("tbl%0d", i), tbl[i].ev, tbl[i].ed,
                 tbl[i].es, tbl[i].ea);
      end

      // mid-stream asynchronous reset while FULL
      req = 8'hFF;
      dat = BASE;
      rdy = 1'b0;
      step();
      chk("pre_rst.valid", 64'(o_valid), 64'd1);
      #2 rst_n = 1'b0;
      #1 chk_out("async_rst", 1'b0, 8'h00, 8'h00, 8'h00);
      @(negedge clk);
      rst_n = 1'b1;
      rdy = 1'b1;
      step();
      chk_out("post_rst", 1'b1, 8'h10, 8'h01, 8'h01);

      // backpressure: hold lane 1, raise lane 5 during stall
      req = 8'h02;
      dat = BASE;
      rdy = 1'b1;
      step();
      chk_out("bp_load", 1'b1, 8'h11, 8'h02, 8'h02);
      req = 8'h20;
      rdy = 1'b0;
      for (int c = 0; c < 3; c++) begin
         step();
         chk_out($sformatf("bp_stall%0d", c), 1'b1, 8'h11, 8'h02, 8'h00);
      end
      rdy = 1'b1;
      step();
      chk_out("bp_release", 1'b1, 8'h15, 8'h20, 8'h20);
      req = 8'h00;
      step();
      chk_out("bp_drain", 1'b0, 8'h15, 8'h00, 8'h00);

      // no duplicate: lane 2 holds req one cycle past its ack
      acks = 0;
      req = 8'h04;
      step();
      if (o_ack == 8'h04) acks++;
      chk_out("nodup0", 1'b1, 8'h12, 8'h04, 8'h04);
      step();
      if (o_ack == 8'h04) acks++;
      chk_out("nodup1", 1'b0, 8'h12, 8'h00, 8'h00);
      req = 8'h00;
      step();
      if (o_ack == 8'h04) acks++;
      chk_out("nodup2", 1'b0, 8'h12, 8'h00, 8'h00);
      chk("nodup.acks", 64'(acks), 64'd1);

      // randomized traffic against the model
      rst_n = 1'b0;
      #1;
      m_reset();
      @(negedge clk);
      rst_n = 1'b1;
      pend   = '0;
      lane_d = '0;
      for (int c = 0; c < 400; c++) begin
         for (int k = 0; k < 8; k++) begin
            if (m_ack[k]) pend[k] = 1'b0;
            if (!pend[k] && $urandom_range(2) == 0) begin
               pend[k] = 1'b1;
               lane_d[8*k +: 8] = 8'($urandom);
            end
         end
         req = pend;
         dat = lane_d;
         rdy = ($urandom_range(3) != 0);
         m_next(req, dat, rdy);
         step();
         chk_out($sformatf("rnd%0d", c), m_valid, 8'(m_data),
                 8'(m_sel), 8'(m_ack));
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
